axis_frame_tagger: RTL and testbench

AXIS_FRAME_TAGGER -- requirements
Module: axis_frame_tagger

---
 rtl/axis_frame_tagger.sv | 187 ++++++++++++++++++
 tb/tb_axis_frame_tagger.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_tagger.sv
// AXI-Stream frame tagger: counts samples through a cols/rows/bands/slices
// geometry and tags each beat with end-of-row/band/slice/image flags.
// Geometry is latched on the first beat of every image; a single output
// register stage gives full throughput with one cycle of latency.
module axis_frame_tagger #(
  parameter int DATA_WIDTH          = 16,
  parameter int DIM_WIDTH           = 8,
  parameter int CHECK_UPSTREAM_LAST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIM_WIDTH-1:0]  cfg_cols_m1,
  input  logic [DIM_WIDTH-1:0]  cfg_rows_m1,
  input  logic [DIM_WIDTH-1:0]  cfg_bands_m1,
  input  logic [DIM_WIDTH-1:0]  cfg_slices_m1,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_last,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_last_r,
  output logic                  y_last_b,
  output logic                  y_last_s,
  output logic                  y_last_i,
  output logic                  y_err,
  output logic                  err_sticky,
  output logic                  busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [DIM_WIDTH-1:0]    cols_q, rows_q, bands_q, slices_q;
  logic [DIM_WIDTH-1:0]    cols_d, rows_d, bands_d, slices_d;
  logic [DIM_WIDTH-1:0]    col_q, row_q, band_q, slice_q;
  logic [DIM_WIDTH-1:0]    col_d, row_d, band_d, slice_d;
  logic                    y_valid_q, y_valid_d;
  logic [DATA_WIDTH-1:0]   y_data_q, y_data_d;
  logic                    y_last_r_q, y_last_b_q, y_last_s_q, y_last_i_q;
  logic                    y_last_r_d, y_last_b_d, y_last_s_d, y_last_i_d;
  logic                    y_err_q, y_err_d;
  logic                    err_sticky_q, err_sticky_d;

  logic                    accept;
  logic [DIM_WIDTH-1:0]    eff_cols, eff_rows, eff_bands, eff_slices;
  logic                    last_r, last_b, last_s, last_i, err_now;

  // In IDLE the beat being accepted is tagged with the live cfg inputs,
  // since those are exactly the values being latched on this edge.
  assign eff_cols   = (state_q == IDLE) ? cfg_cols_m1   : cols_q;
  assign eff_rows   = (state_q == IDLE) ? cfg_rows_m1   : rows_q;
  assign eff_bands  = (state_q == IDLE) ? cfg_bands_m1  : bands_q;
  assign eff_slices = (state_q == IDLE) ? cfg_slices_m1 : slices_q;

  assign last_r  = (col_q == eff_cols);
  assign last_b  = last_r && (row_q == eff_rows);
  assign last_s  = last_b && (band_q == eff_bands);
  assign last_i  = last_s && (slice_q == eff_slices);
  assign err_now = (CHECK_UPSTREAM_LAST != 0) ? (x_last ^ last_i) : 1'b0;

  // Ready is forced high during reset so upstream never sees a stalled port.
  assign x_ready = rst || !y_valid_q || y_ready;
  assign accept  = x_valid && x_ready;

  assign y_valid    = y_valid_q;
  assign y_data     = y_data_q;
  assign y_last_r   = y_last_r_q;
  assign y_last_b   = y_last_b_q;
  assign y_last_s   = y_last_s_q;
  assign y_last_i   = y_last_i_q;
  assign y_err      = y_err_q;
  assign err_sticky = err_sticky_q;
  assign busy       = (state_q == RUN);

  // Next-state: FSM, cfg latch, geometry counters and output register.
  always_comb begin
    state_d      = state_q;
    cols_d       = cols_q;
    rows_d       = rows_q;
    bands_d      = bands_q;
    slices_d     = slices_q;
    col_d        = col_q;
    row_d        = row_q;
    band_d       = band_q;
    slice_d      = slice_q;
    y_valid_d    = y_valid_q;
    y_data_d     = y_data_q;
    y_last_r_d   = y_last_r_q;
    y_last_b_d   = y_last_b_q;
    y_last_s_d   = y_last_s_q;
    y_last_i_d   = y_last_i_q;
    y_err_d      = y_err_q;
    err_sticky_d = err_sticky_q;

    if (y_ready) begin
      y_valid_d = 1'b0;
    end

    if (accept) begin
      y_valid_d    = 1'b1;
      y_data_d     = x_data;
      y_last_r_d   = last_r;
      y_last_b_d   = last_b;
      y_last_s_d   = last_s;
      y_last_i_d   = last_i;
      y_err_d      = err_now;
      err_sticky_d = err_sticky_q | err_now;

      if (state_q == IDLE) begin
        cols_d   = cfg_cols_m1;
        rows_d   = cfg_rows_m1;
        bands_d  = cfg_bands_m1;
        slices_d = cfg_slices_m1;
      end

      if (last_i) begin
        col_d   = '0;
        row_d   = '0;
        band_d  = '0;
        slice_d = '0;
        state_d = IDLE;
      end else begin
        state_d = RUN;
        if (!last_r) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          if (!last_b) begin
            row_d = row_q + 1'b1;
          end else begin
            row_d = '0;
            if (!last_s) begin
              band_d = band_q + 1'b1;
            end else begin
              band_d  = '0;
              slice_d = slice_q + 1'b1;
            end
          end
        end
      end
    end
  end

  // State register with synchronous reset; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cols_q       <= '0;
      rows_q       <= '0;
      bands_q      <= '0;
      slices_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      band_q       <= '0;
      slice_q      <= '0;
      y_valid_q    <= 1'b0;
      y_data_q     <= '0;
      y_last_r_q   <= 1'b0;
      y_last_b_q   <= 1'b0;
      y_last_s_q   <= 1'b0;
      y_last_i_q   <= 1'b0;
      y_err_q      <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      bands_q      <= bands_d;
      slices_q     <= slices_d;
      col_q        <= col_d;
      row_q        <= row_d;
      band_q       <= band_d;
      slice_q      <= slice_d;
      y_valid_q    <= y_valid_d;
      y_data_q     <= y_data_d;
      y_last_r_q   <= y_last_r_d;
      y_last_b_q   <= y_last_b_d;
      y_last_s_q   <= y_last_s_d;
      y_last_i_q   <= y_last_i_d;
      y_err_q      <= y_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_tagger.sv
// Bench for axis_frame_tagger: scenario table, hand sequences for reset and
// cfg-change corners, and a randomized run against an arithmetic model.
module tb_axis_frame_tagger;
  localparam int DW = 16;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] cfg_cols_m1, cfg_rows_m1, cfg_bands_m1, cfg_slices_m1;
  logic          x_valid, x_ready, x_last;
  logic [DW-1:0] x_data;
  logic          y_valid, y_ready;
  logic [DW-1:0] y_data;
  logic          y_last_r, y_last_b, y_last_s, y_last_i, y_err, err_sticky, busy;

  always #5 clk = ~clk;

  axis_frame_tagger #(.DATA_WIDTH(DW), .DIM_WIDTH(MW), .CHECK_UPSTREAM_LAST(1)) dut (
    .clk(clk), .rst(rst),
    .cfg_cols_m1(cfg_cols_m1), .cfg_rows_m1(cfg_rows_m1),
    .cfg_bands_m1(cfg_bands_m1), .cfg_slices_m1(cfg_slices_m1),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_last_r(y_last_r), .y_last_b(y_last_b), .y_last_s(y_last_s), .y_last_i(y_last_i),
    .y_err(y_err), .err_sticky(err_sticky), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic lr, lb, ls, li, err;
  } beat_t;

  typedef struct {
    int c, r, b, s, nb, xmode, rmode, rvalid;
    int er, eb, es, ei, eerr;
  } scen_t;

  beat_t exp_q[$];
  scen_t tbl[6];

  int n_cmp = 0;
  int n_bad = 0;
  int rmode = 0;
  bit rvalid = 0;
  int cyc = 0;

  // model state (image-relative beat index and geometry latched at image start)
  int m_n = 0;
  int mc = 1, mr = 1, mb = 1, ms = 1;
  bit m_sticky = 0;
  bit prev_stall = 0;
  logic [DW+4:0] held;
  int cnt_r = 0, cnt_b = 0, cnt_s = 0, cnt_i = 0, cnt_err = 0, cnt_beats = 0;

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // output-ready pattern generator
  initial begin
    y_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rmode)
        0: y_ready = 1'b1;
        1: y_ready = ((cyc % 4) == 0);
        2: y_ready = ($urandom_range(0, 1) == 1);
        default: y_ready = 1'b0;
      endcase
    end
  end

  // monitor and reference model, sampled on the falling edge
  always @(negedge clk) begin
    beat_t e;
    int col, row, band, slice;
    if (rst) begin
      exp_q.delete();
      m_n = 0;
      m_sticky = 0;
      prev_stall = 0;
    end else begin
      check("busy", busy, (m_n != 0));
      if (prev_stall) begin
        check("hold_valid", y_valid, 1);
        check("hold_beat", {y_data, y_last_r, y_last_b, y_last_s, y_last_i, y_err}, held);
      end
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", y_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {y_data, y_last_r, y_last_b, y_last_s, y_last_i, y_err},
                {e.d, e.lr, e.lb, e.ls, e.li, e.err});
          m_sticky = m_sticky | e.err;
          check("sticky", err_sticky, m_sticky);
        end
        cnt_r += int'(y_last_r); cnt_b += int'(y_last_b);
        cnt_s += int'(y_last_s); cnt_i += int'(y_last_i);
        cnt_err += int'(y_err); cnt_beats++;
      end
      prev_stall = y_valid && !y_ready;
      held = {y_data, y_last_r, y_last_b, y_last_s, y_last_i, y_err};
      if (x_valid && x_ready) begin
        if (m_n == 0) begin
          mc = int'(cfg_cols_m1) + 1;  mr = int'(cfg_rows_m1) + 1;
          mb = int'(cfg_bands_m1) + 1; ms = int'(cfg_slices_m1) + 1;
        end
        col   = m_n % mc;
        row   = (m_n / mc) % mr;
        band  = (m_n / (mc * mr)) % mb;
        slice = m_n / (mc * mr * mb);
        e.d   = x_data;
        e.lr  = (col == mc - 1);
        e.lb  = e.lr && (row == mr - 1);
        e.ls  = e.lb && (band == mb - 1);
        e.li  = e.ls && (slice == ms - 1);
        e.err = x_last ^ e.li;
        exp_q.push_back(e);
        m_n = e.li ? 0 : m_n + 1;
      end
    end
  end

  task automatic set_cfg(input int c, input int r, input int b, input int s);
    cfg_cols_m1 = MW'(c); cfg_rows_m1 = MW'(r);
    cfg_bands_m1 = MW'(b); cfg_slices_m1 = MW'(s);
  endtask

  // called at posedge+1; checks reset values, leaves rst low at posedge+1
  task automatic do_reset();
    rst = 1'b1;
    x_valid = 1'b0;
    #1;
    check("rst_x_ready_during", x_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    check("rst_flags", {y_last_r, y_last_b, y_last_s, y_last_i, y_err}, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_busy", busy, 0);
    check("rst_x_ready", x_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic xl);
    int guard;
    bit acc;
    if (rvalid) begin
      while ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
    x_valid = 1'b1;
    x_data = d;
    x_last = xl;
    guard = 0;
    acc = 0;
    do begin
      @(negedge clk);
      acc = x_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 2000);
    if (!acc) check("send_timeout", acc, 1);
    x_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || y_valid) && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int tot, b0r, b0b, b0s, b0i, b0e, b0n;
    logic xl;

    tbl[0] = '{3, 1, 1, 1, 32, 0, 0, 0, 8, 4, 2, 1, 0};
    tbl[1] = '{0, 0, 0, 0,  5, 1, 0, 0, 5, 5, 5, 5, 0};
    tbl[2] = '{3, 1, 1, 1, 32, 0, 1, 1, 8, 4, 2, 1, 0};
    tbl[3] = '{3, 1, 1, 1, 32, 2, 0, 0, 8, 4, 2, 1, 2};
    tbl[4] = '{1, 2, 0, 0, 12, 0, 2, 1, 6, 2, 2, 2, 0};
    tbl[5] = '{2, 0, 1, 0,  6, 0, 2, 0, 2, 2, 1, 1, 0};

    rst = 1'b1; x_valid = 1'b0; x_data = '0; x_last = 1'b0;
    set_cfg(0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      set_cfg(tbl[i].c, tbl[i].r, tbl[i].b, tbl[i].s);
      rmode = tbl[i].rmode;
      rvalid = (tbl[i].rvalid != 0);
      do_reset();
      tot = (tbl[i].c + 1) * (tbl[i].r + 1) * (tbl[i].b + 1) * (tbl[i].s + 1);
      b0r = cnt_r; b0b = cnt_b; b0s = cnt_s; b0i = cnt_i; b0e = cnt_err; b0n = cnt_beats;
      for (int k = 0; k < tbl[i].nb; k++) begin
        case (tbl[i].xmode)
          0: xl = (((k + 1) % tot) == 0);
          1: xl = 1'b1;
          default: xl = (k + 1 == 16);
        endcase
        send(DW'($urandom_range(1, 65535)), xl);
      end
      drain();
      check($sformatf("s%0d_beats", i), cnt_beats - b0n, tbl[i].nb);
      check($sformatf("s%0d_last_r", i), cnt_r - b0r, tbl[i].er);
      check($sformatf("s%0d_last_b", i), cnt_b - b0b, tbl[i].eb);
      check($sformatf("s%0d_last_s", i), cnt_s - b0s, tbl[i].es);
      check($sformatf("s%0d_last_i", i), cnt_i - b0i, tbl[i].ei);
      check($sformatf("s%0d_err", i), cnt_err - b0e, tbl[i].eerr);
    end

    // reset in the middle of an image with a beat held in the output stage
    set_cfg(3, 1, 1, 1);
    rmode = 0; rvalid = 0;
    do_reset();
    for (int k = 0; k < 10; k++) send(DW'(16'h1000 + k), (k == 4));
    rmode = 3;
    repeat (2) begin @(posedge clk); #1; end
    send(16'hBEEF, 1'b0);
    @(negedge clk);
    check("mid_held_valid", y_valid, 1);
    check("mid_sticky_set", err_sticky, 1);
    @(posedge clk); #1;
    do_reset();
    set_cfg(1, 0, 0, 0);
    rmode = 0;
    b0r = cnt_r; b0i = cnt_i; b0n = cnt_beats;
    send(16'h0A0A, 1'b0);
    send(16'h0B0B, 1'b1);
    drain();
    check("mid_beats", cnt_beats - b0n, 2);
    check("mid_last_r", cnt_r - b0r, 1);
    check("mid_last_i", cnt_i - b0i, 1);
    check("mid_sticky_clear", err_sticky, 0);

    // back-to-back images, cfg changed while an image is running
    set_cfg(1, 1, 0, 0);
    rvalid = 1;
    b0r = cnt_r; b0i = cnt_i; b0e = cnt_err;
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    set_cfg(2, 0, 0, 0);
    send(16'h0003, 1'b0);
    send(16'h0004, 1'b1);
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b0);
    send(16'h0007, 1'b1);
    drain();
    check("b2b_last_r", cnt_r - b0r, 3);
    check("b2b_last_i", cnt_i - b0i, 2);
    check("b2b_err", cnt_err - b0e, 0);

    // randomized images with random stalls, occasional bad x_last, cfg noise
    rmode = 2; rvalid = 1;
    for (int img = 0; img < 8; img++) begin
      int c, r, b, s;
      c = int'($urandom_range(0, 2)); r = int'($urandom_range(0, 2));
      b = int'($urandom_range(0, 2)); s = int'($urandom_range(0, 2));
      set_cfg(c, r, b, s);
      tot = (c + 1) * (r + 1) * (b + 1) * (s + 1);
      for (int k = 0; k < tot; k++) begin
        xl = (k == tot - 1);
        if ($urandom_range(0, 7) == 0) xl = !xl;
        send(DW'($urandom), xl);
        if (k == 0) set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end
    drain();
    repeat (3) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
